// File: rtl/fifo_ctrl_ram64.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl_ram64
// Brief    : FIFO controller for an external 64x8 RAM with a registered read.
//            Holds the pointers, occupancy count, flags and read-valid retiming.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ctrl_ram64 #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow,
    output logic          ram_we,
    output logic [DW-1:0] ram_data,
    output logic [AW-1:0] ram_write_addr,
    output logic [AW-1:0] ram_read_addr,
    input  logic [DW-1:0] ram_q
);

    localparam logic [AW:0] c_DEPTH = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_rd_valid;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;

    // Flags are decoded from the count register, so they always reflect
    // the occupancy at the start of the current cycle.
    assign w_full   = (r_count == c_DEPTH);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wr_en & ~w_full;
    assign w_rd_acc = rd_en & ~w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            // The RAM returns data one cycle after the read address is
            // presented, so the valid strobe is the accepted pop delayed once.
            r_rd_valid  <= w_rd_acc;
            r_overflow  <= r_overflow  | (wr_en & w_full);
            r_underflow <= r_underflow | (rd_en & w_empty);
        end
    end

    assign ram_we         = w_wr_acc;
    assign ram_data       = wr_data;
    assign ram_write_addr = r_wr_ptr;
    assign ram_read_addr  = r_rd_ptr;
    assign rd_data        = ram_q;

    assign rd_valid  = r_rd_valid;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl_ram64.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_ctrl_ram64
// Brief    : Scoreboard bench for fifo_ctrl_ram64 with a behavioural RAM and a
//            queue-based FIFO reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl_ram64;

    localparam int c_AW    = 6;
    localparam int c_DW    = 8;
    localparam int c_DEPTH = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [c_DW-1:0]   wr_data = '0;
    logic              rd_en = 1'b0;
    logic [c_DW-1:0]   rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic [c_AW:0]     count;
    logic              overflow;
    logic              underflow;
    logic              ram_we;
    logic [c_DW-1:0]   ram_data;
    logic [c_AW-1:0]   ram_write_addr;
    logic [c_AW-1:0]   ram_read_addr;
    logic [c_DW-1:0]   ram_q;

    fifo_ctrl_ram64 #(.AW(c_AW), .DW(c_DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .full           (full),
        .empty          (empty),
        .count          (count),
        .overflow       (overflow),
        .underflow      (underflow),
        .ram_we         (ram_we),
        .ram_data       (ram_data),
        .ram_write_addr (ram_write_addr),
        .ram_read_addr  (ram_read_addr),
        .ram_q          (ram_q)
    );

    always #5 clk = ~clk;

    // Single-port style RAM: registered read, old data on address collision.
    logic [c_DW-1:0] mem [c_DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_write_addr] <= ram_data;
        ram_q <= mem[ram_read_addr];
    end

    // Reference model: FIFO contents as a queue, pointers as plain counters.
    logic [c_DW-1:0] model_q[$];
    logic [c_DW-1:0] exp_q[$];
    int m_wptr = 0;
    int m_rptr = 0;
    bit m_ovf  = 1'b0;
    bit m_unf  = 1'b0;
    bit m_rdv  = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
        m_wptr = 0;
        m_rptr = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_rdv  = 1'b0;
    endtask

    // One clock cycle of stimulus; the model commits on the same edge as the DUT.
    task automatic cycle(input bit we, input logic [c_DW-1:0] wd, input bit re);
        bit f, e, aw, ar;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        f  = (model_q.size() == c_DEPTH);
        e  = (model_q.size() == 0);
        aw = we && !f;
        ar = re && !e;
        #1;
        chk("ram_we", 32'(ram_we), 32'(aw));
        if (aw) chk("ram_data", 32'(ram_data), 32'(wd));
        @(posedge clk);
        if (we && f) m_ovf = 1'b1;
        if (re && e) m_unf = 1'b1;
        if (ar) begin
            exp_q.push_back(model_q.pop_front());
            m_rptr = (m_rptr + 1) % c_DEPTH;
        end
        if (aw) begin
            model_q.push_back(wd);
            m_wptr = (m_wptr + 1) % c_DEPTH;
        end
        m_rdv = ar;
        #1;
    endtask

    // Asserts reset away from any edge and checks that state clears at once.
    task automatic async_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_wr_addr", 32'(ram_write_addr), 32'd0);
        chk("rst_rd_addr", 32'(ram_read_addr), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        model_reset();
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: state compared every cycle, data popped from the scoreboard on rd_valid.
    always @(negedge clk) begin
        if (!rst) begin
            chk("count", 32'(count), 32'(model_q.size()));
            chk("full", 32'(full), 32'(model_q.size() == c_DEPTH));
            chk("empty", 32'(empty), 32'(model_q.size() == 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_unf));
            chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
            chk("ram_write_addr", 32'(ram_write_addr), 32'(m_wptr));
            chk("ram_read_addr", 32'(ram_read_addr), 32'(m_rptr));
            if (rd_valid) begin
                if (exp_q.size() == 0) chk("rd_data_unexpected", 32'd1, 32'd0);
                else chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        chk("init_count", 32'(count), 32'd0);
        chk("init_empty", 32'(empty), 32'd1);
        chk("init_ram_we", 32'(ram_we), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        repeat (3) cycle(1'b0, 8'h00, 1'b0);

        // Three pushes then three pops
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        repeat (3) cycle(1'b0, 8'h00, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);

        // Fill to full, overflow attempt, drain
        for (int i = 0; i < 64; i++) cycle(1'b1, 8'(i), 1'b0);
        cycle(1'b1, 8'h40, 1'b0);
        for (int i = 0; i < 64; i++) cycle(1'b0, 8'h00, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);

        // Pointer wrap-around
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);

        async_reset();

        // Simultaneous push/pop at count 5, then at empty and at full
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h60 + i), 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h77, 1'b1);
        for (int i = 0; i < 63; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        cycle(1'b1, 8'hEE, 1'b1);
        for (int i = 0; i < 63; i++) cycle(1'b0, 8'h00, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 99) < 50));
        end
        while (model_q.size() > 0) cycle(1'b0, 8'h00, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);

        // Reset mid-stream at count 20 with a pop in flight
        async_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        rd_en = 1'b1;
        @(negedge clk);
        chk("pre_rst_rd_valid", 32'(rd_valid), 32'd1);
        async_reset();
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);

        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_ctrl_ram64.md
# fifo_ctrl_ram64

Synchronous FIFO controller that sits directly upstream of the 64x8 single-port RAM (separate read/write address ports, registered read, old-data-on-collision). Drives the RAM's write enable, write data, and write/read addresses from push/pop requests, and tracks occupancy. Re-times the RAM's one-cycle registered read into a data-valid strobe for the consumer. The RAM is an external instance; this block contains only pointers, counters, flags and handshake logic.

## Interface
Parameters:
- AW, 6, address width; depth = 2^AW = 64
- DW, 8, data width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  push request
- wr_data  in  DW  push data
- rd_en  in  1  pop request
- rd_data  out  DW  popped data; passthrough of ram_q
- rd_valid  out  1  rd_data valid this cycle
- full  out  1  count == 64
- empty  out  1  count == 0
- count  out  AW+1  occupancy, 0..64
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty
- ram_we  out  1  to RAM we
- ram_data  out  DW  to RAM data
- ram_write_addr  out  AW  to RAM write_addr
- ram_read_addr  out  AW  to RAM read_addr
- ram_q  in  DW  from RAM q

## Operation
- Push accepted: wr_acc = wr_en & ~full. Pop accepted: rd_acc = rd_en & ~empty. Both are evaluated on start-of-cycle flag values.
- Combinational outputs:
  - ram_we = wr_acc
  - ram_data = wr_data
  - ram_write_addr = wr_ptr
  - ram_read_addr = rd_ptr
  - rd_data = ram_q
- Registered state: wr_ptr, rd_ptr (AW bits), count, rd_valid, overflow, underflow.
- On wr_acc: wr_ptr increments, wrapping 63 -> 0.
- On rd_acc: rd_ptr increments, wrapping 63 -> 0.
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
- full = (count == 64) and empty = (count == 0), both decoded from the count register. No separate flag state.
- rd_valid <= rd_acc.
- overflow <= overflow | (wr_en & full). underflow <= underflow | (rd_en & empty). Cleared only by rst.
- Boundary behaviour:
  - Full with push and pop in the same cycle: pop accepted, push rejected, overflow set, count becomes 63.
  - Empty with push and pop in the same cycle: push accepted, pop rejected, underflow set, count becomes 1. No write-through bypass.
  - Otherwise, simultaneous push and pop are both accepted and count holds.
  - Read/write address collision in the same cycle occurs only when the FIFO is full (rejected write) or empty (rejected read). Neither returns data, so the RAM's old-data collision rule never reaches the consumer.
  - Reset mid-operation clears pointers, count and flags, and drops rd_valid immediately. RAM contents are not cleared; stale entries are unreachable.

## Timing
- Reset values: rd_valid 0, full 0, empty 1, count 0, overflow 0, underflow 0, ram_we 0 (while wr_en = 0), ram_write_addr 0, ram_read_addr 0. rd_data follows ram_q and is undefined until the first pop.
- Write latency: data pushed in cycle N is poppable from cycle N+1, because empty deasserts after edge N.
- Read latency: pop accepted in cycle N presents data on rd_data with rd_valid = 1 in cycle N+1, for exactly one cycle per accepted pop.
- Back-to-back pops give one datum per cycle, with rd_valid held high continuously.
- Flags update on the same edge as the pointers and are visible the cycle after the causing push/pop.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Reset, then idle 3 cycles -> empty = 1, full = 0, count = 0, rd_valid = 0, both sticky flags 0.
- Push 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 on consecutive cycles -> rd_valid high for 3 cycles, each one cycle after its pop; rd_data = 0x11, 0x22, 0x33; count returns to 0; empty = 1.
- Push 64 values 0x00..0x3F -> full = 1 and count = 64 after the 64th edge. A 65th push leaves count at 64 and sets overflow. Popping all 64 returns 0x00..0x3F in order.
- Wrap-around: push 40, pop 40, push 40 (wr_ptr wraps to 16), pop 40 -> data in order, ram_write_addr shows 63 -> 0 transition, count ends at 0.
- Simultaneous push and pop at count 5 for 10 cycles -> count stays 5 and rd_valid stays high. At empty, push+pop -> count 1, underflow = 1. At full, push+pop -> count 63, overflow = 1.
- Assert rst mid-stream at count 20 with a pop pending -> rd_valid, count and pointers go to 0 immediately (asynchronously) and empty = 1. A subsequent push/pop of 0xA5 returns 0xA5.
